// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin two-master sequencer in front of the single-transaction I/O controller port
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   M0_*/M1_*                 master request (ADDR, DIN, WE, RREQ) and completion (DO, RDY, ERR)
//   IO_ADDR/IO_DIN/IO_WE/IO_RREQ  registered request to the controller, strobes one cycle wide
//   IO_DO/IO_RDY              controller read data and completion pulse
//   BUSY                      high whenever a transaction is in flight
// Optional: define IO_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT cycles with ERR=1.
module io_bus_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M0_DIN,
  input  logic [31:0] M1_DIN,
  input  logic        M0_WE,
  input  logic        M1_WE,
  input  logic        M0_RREQ,
  input  logic        M1_RREQ,
  output logic [31:0] M0_DO,
  output logic [31:0] M1_DO,
  output logic        M0_RDY,
  output logic        M1_RDY,
  output logic        M0_ERR,
  output logic        M1_ERR,
  output logic [31:0] IO_ADDR,
  output logic [31:0] IO_DIN,
  output logic        IO_WE,
  output logic        IO_RREQ,
  input  logic [31:0] IO_DO,
  input  logic        IO_RDY,
  output logic        BUSY
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic last_grant, grant, err, any, pick, sel_we, ok, to, fin;
  logic [31:0] sel_addr, sel_din, fin_do;
  if (TIMEOUT < 4) begin : g_bad_timeout
    $error("io_bus_arbiter: TIMEOUT must be at least 4");
  end
`ifdef IO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
`endif
  always_comb begin
    any = M0_WE | M0_RREQ | M1_WE | M1_RREQ;
    pick = ((M0_WE | M0_RREQ) & (M1_WE | M1_RREQ)) ? ~last_grant : (M1_WE | M1_RREQ);
    sel_addr = pick ? M1_ADDR : M0_ADDR;
    sel_din = pick ? M1_DIN : M0_DIN;
    sel_we = pick ? M1_WE : M0_WE;
    ok = (state == WAIT) && IO_RDY;
`ifdef IO_ARB_TIMEOUT_EN
    to = (state == WAIT) && !IO_RDY && (cnt == CW'(TIMEOUT - 1));
`else
    to = 1'b0;
`endif
    // error grants spend their ISSUE slot with strobes suppressed, completing one edge after the grant
    fin = ok | to | ((state == ISSUE) && err);
    fin_do = ok ? IO_DO : '1;
    nxt = fin ? DONE : (state == IDLE) ? (any ? ISSUE : IDLE) : (state == ISSUE) ? WAIT : (state == DONE) ? IDLE : WAIT;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      err <= 1'b0;
      IO_ADDR <= '0;
      IO_DIN <= '0;
      IO_WE <= 1'b0;
      IO_RREQ <= 1'b0;
      M0_DO <= '0;
      M1_DO <= '0;
      M0_RDY <= 1'b0;
      M1_RDY <= 1'b0;
      M0_ERR <= 1'b0;
      M1_ERR <= 1'b0;
      BUSY <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      state <= nxt;
      BUSY <= nxt != IDLE;
      IO_WE <= (state == IDLE) && any && sel_addr[31] && sel_we;
      IO_RREQ <= (state == IDLE) && any && sel_addr[31] && !sel_we;
      M0_RDY <= fin && !grant;
      M1_RDY <= fin && grant;
      M0_ERR <= fin && !grant && !ok;
      M1_ERR <= fin && grant && !ok;
      if (fin && !grant) M0_DO <= fin_do;
      if (fin && grant) M1_DO <= fin_do;
      if ((state == IDLE) && any) begin
        grant <= pick;
        last_grant <= pick;
        IO_ADDR <= sel_addr;
        IO_DIN <= sel_din;
        err <= !sel_addr[31];
      end
`ifdef IO_ARB_TIMEOUT_EN
      cnt <= (state == WAIT) ? cnt + CW'(1) : '0;
`endif
    end
  end
endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter and sequencer in front of the memory-mapped I/O controller (the `ADDR[31]`-selected peripheral space: switches, LEDs, GPIO, 7-segment, UART). It lets the CPU load/store path (master 0) and a second requester (master 1, the UART debug/loader bridge) share the controller's single-transaction `WE`/`RREQ`/`RDY` port. It grants round-robin, issues each access as a single-cycle strobe, waits for the controller's `RDY` pulse and returns read data with a one-cycle completion pulse to the granted master.

## Interface
- `TIMEOUT`, 64: cycles to wait for `IO_RDY` after the strobe before aborting; must be ≥ 4. Used only with `IO_ARB_TIMEOUT_EN`.
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `M0_ADDR`, `M1_ADDR`  in  32  request address; bit 31 selects I/O space, bits [7:0] the register.
- `M0_DIN`, `M1_DIN`  in  32  write data; the controller uses bits [7:0].
- `M0_WE`, `M1_WE`  in  1  write request (level).
- `M0_RREQ`, `M1_RREQ`  in  1  read request (level).
- `M0_DO`, `M1_DO`  out  32  read data, valid while the matching `Mx_RDY` is 1.
- `M0_RDY`, `M1_RDY`  out  1  one-cycle completion pulse.
- `M0_ERR`, `M1_ERR`  out  1  error flag, valid with `Mx_RDY`.
- `IO_ADDR`, `IO_DIN`  out  32  to the controller `ADDR`/`DIN`.
- `IO_WE`, `IO_RREQ`  out  1  to the controller; single-cycle strobes.
- `IO_DO`  in  32  from the controller `DO`.
- `IO_RDY`  in  1  from the controller `RDY`.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- Master handshake:
  - Hold `Mx_WE` or `Mx_RREQ`, with address and data stable, until `Mx_RDY` is sampled at 1.
  - Deassert on that same edge.
  - If both `WE` and `RREQ` are set, the access is a write.
- States:
  - **IDLE**: on any pending request, pick the grant, latch `IO_ADDR`/`IO_DIN`/type, and go to ISSUE. If `ADDR[31]`=0, go to DONE instead with `ERR`=1, `DO`=0xFFFFFFFF, and no downstream access.
  - **ISSUE**: exactly one cycle with `IO_WE` or `IO_RREQ`=1, then go to WAIT.
  - **WAIT**: strobes are 0 and `IO_ADDR`/`IO_DIN` are held. On `IO_RDY`=1, capture `IO_DO` into the granted `Mx_DO` (writes also return `IO_DO`), set `ERR`=0, and go to DONE.
  - **DONE**: the granted `Mx_RDY`=1 for one cycle, then go to IDLE.
- Arbitration:
  - Round-robin on a `last_grant` bit. When both masters request in IDLE, grant the one that was not granted last.
  - A single requester is always granted.
  - `last_grant` updates on every grant, including error grants.
- `IO_RDY` is ignored outside WAIT. This covers the controller's post-reset `RDY` pulse.
- The non-granted master's `RDY`/`ERR` stay 0 and its `DO` holds its previous value.

## Timing
- Reset values: `IO_WE`=`IO_RREQ`=0, `IO_ADDR`=`IO_DIN`=0, `M0/M1_RDY`=0, `M0/M1_ERR`=0, `M0/M1_DO`=0, `BUSY`=0, state IDLE, `last_grant`=1 (master 0 wins first).
- With the I/O controller (strobe to `RDY` takes 3 edges), timed from request sampled at edge E:
  - E: ISSUE.
  - E+1: strobe sampled by the controller, arbiter enters WAIT.
  - E+3: controller `RDY`=1.
  - E+4: `Mx_RDY`=1.
  - E+5: IDLE.
  - E+6: earliest next grant.
- Back-to-back requests from the same master have a throughput of one access per 6 cycles.
- The strobe must never be asserted for more than one cycle, because the controller re-triggers on a held request.
- A `ADDR[31]`=0 request reaches DONE at E+1.
- Reset mid-transaction: abort immediately, all outputs go to reset values and no `Mx_RDY` is issued. The master must re-issue.

## Configuration
- `IO_ARB_TIMEOUT_EN` defined:
  - A counter starts at WAIT entry.
  - If `IO_RDY` is not seen within `TIMEOUT` cycles in WAIT, go to DONE with `ERR`=1 and `DO`=0xFFFFFFFF.
  - A late `IO_RDY` is then ignored.
- `IO_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT lasts indefinitely.
  - `ERR` is asserted only for `ADDR[31]`=0 requests.

## Test plan
- M0 read, `ADDR`=0x8000000F, controller model returns `DO`=0x5A three cycles after the strobe -> `IO_RREQ` high for exactly 1 cycle, `M0_RDY` at E+4 with `M0_DO`=0x5A, `M0_ERR`=0.
- M0 and M1 both write in the same cycle right after reset (`ADDR`=0x80000001, `DIN`=0xA5 / 0x3C) -> M0 served first, then M1. The downstream write data sequence is 0xA5 then 0x3C. A repeat simultaneous pair is served M1 first.
- M1 read with `ADDR`=0x00000010 -> `M1_RDY` at E+1 with `ERR`=1, `DO`=0xFFFFFFFF, no `IO_WE`/`IO_RREQ` activity.
- `IO_RDY` pulsed while IDLE, and a stray `IO_RDY` during ISSUE -> no `Mx_RDY`, no state change from IDLE.
- `RST` asserted in WAIT -> next cycle all outputs at reset values, no `RDY`. The same request re-issued afterwards completes normally.
- With `IO_ARB_TIMEOUT_EN` and `TIMEOUT`=8, controller never asserts `RDY` -> `M0_RDY`=1 with `ERR`=1 and `DO`=0xFFFFFFFF after 8 WAIT cycles; a later `IO_RDY` is ignored.
